// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus bundle for the load/store unit.
// Ports: req_* / resp_* pipeline handshake, mem_* word-wide memory bus, busy status.
interface load_store_unit_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_rdata;

    logic              busy;

    // Pipeline and memory side: drives requests and memory read data.
    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  mem_addr, mem_wdata, mem_we, mem_re, busy
    );

    // Load/store unit side.
    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output mem_addr, mem_wdata, mem_we, mem_re, busy
    );
endinterface

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte/half/word loads with extension and
// read-modify-write sub-word stores on a memory without byte enables.
// Ports: clk, rst (async, active-high), bus (load_store_unit_if.slave).
module load_store_unit #(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    load_store_unit_if.slave   bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] RESP = 3'd4;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    logic [2:0]        state;
    logic              op_we;
    logic [1:0]        op_size;
    logic              op_signed;
    logic [1:0]        op_off;
    logic [31:0]       op_wdata;

    logic              mem_we_q;
    logic              mem_re_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              resp_valid_q;
    logic [31:0]       resp_rdata_q;
    logic              resp_err_q;

    logic              accept;
    logic              req_err;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       load_data;
    logic [31:0]       merge_data;

    assign bus.req_ready  = (state == IDLE);
    assign bus.busy       = (state != IDLE);
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

    assign accept = bus.req_valid && (state == IDLE);

    // Alignment, size and range check on the live request.
    always_comb begin
        req_err = 1'b0;
        unique case (1'b1)
            (bus.req_size == SZ_B): req_err = 1'b0;
            (bus.req_size == SZ_H): req_err = bus.req_addr[0];
            (bus.req_size == SZ_W): req_err = |bus.req_addr[1:0];
            default:                req_err = 1'b1;
        endcase
        if (|bus.req_addr[31:ADDR_W+2]) begin
            req_err = 1'b1;
        end
    end

    // Lane extraction from the word returned by memory.
    always_comb begin
        lane_b = bus.mem_rdata[7:0];
        unique case (op_off)
            2'd0: lane_b = bus.mem_rdata[7:0];
            2'd1: lane_b = bus.mem_rdata[15:8];
            2'd2: lane_b = bus.mem_rdata[23:16];
            2'd3: lane_b = bus.mem_rdata[31:24];
            default: lane_b = bus.mem_rdata[7:0];
        endcase
        lane_h = op_off[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    end

    always_comb begin
        load_data = bus.mem_rdata;
        unique case (1'b1)
            (op_size == SZ_B):
                load_data = {{24{op_signed & lane_b[7]}}, lane_b};
            (op_size == SZ_H):
                load_data = {{16{op_signed & lane_h[15]}}, lane_h};
            default:
                load_data = bus.mem_rdata;
        endcase
    end

    // Read-modify-write merge: replace only the addressed lane.
    always_comb begin
        merge_data = bus.mem_rdata;
        if (op_size == SZ_B) begin
            unique case (op_off)
                2'd0: merge_data[7:0]   = op_wdata[7:0];
                2'd1: merge_data[15:8]  = op_wdata[7:0];
                2'd2: merge_data[23:16] = op_wdata[7:0];
                2'd3: merge_data[31:24] = op_wdata[7:0];
                default: merge_data = bus.mem_rdata;
            endcase
        end else if (op_off[1]) begin
            merge_data[31:16] = op_wdata[15:0];
        end else begin
            merge_data[15:0] = op_wdata[15:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            op_we        <= 1'b0;
            op_size      <= 2'b00;
            op_signed    <= 1'b0;
            op_off       <= 2'b00;
            op_wdata     <= 32'h0;
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            // Strobes and the response are single-cycle pulses.
            mem_we_q     <= 1'b0;
            mem_re_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        op_we     <= bus.req_we;
                        op_size   <= bus.req_size;
                        op_signed <= bus.req_signed;
                        op_off    <= bus.req_addr[1:0];
                        op_wdata  <= bus.req_wdata;
                        if (req_err) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            mem_addr_q <= bus.req_addr[ADDR_W+1:2];
                            if (bus.req_we && bus.req_size == SZ_W) begin
                                state       <= WR;
                                mem_we_q    <= 1'b1;
                                mem_wdata_q <= bus.req_wdata;
                            end else begin
                                state    <= RD;
                                mem_re_q <= 1'b1;
                            end
                        end
                    end
                end
                RD: begin
                    state <= CAP;
                end
                CAP: begin
                    if (op_we) begin
                        state       <= WR;
                        mem_we_q    <= 1'b1;
                        mem_wdata_q <= merge_data;
                    end else begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_rdata_q <= load_data;
                    end
                end
                WR: begin
                    state        <= RESP;
                    resp_valid_q <= 1'b1;
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Memory-stage initiator for the synchronous word-wide data memory. The memory responds to requests; this block issues them. It accepts one load or store per handshake from the pipeline and converts the byte address to a word index. It performs byte and halfword loads with sign or zero extension, and implements sub-word stores as read-modify-write, because the memory has no byte enables. It returns exactly one response pulse per accepted request.

Parameters:
ADDR_W, 8, word-index width of memory (256 words); byte addresses with req_addr[31:ADDR_W+2] != 0 are out of range

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset, asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  block can accept; combinational, equals (state==IDLE)
req_we  in  1  1=store, 0=load
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
req_signed  in  1  loads only: 1 sign-extend, 0 zero-extend
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
resp_valid  out  1  one-cycle response pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, illegal size or out of range; valid with resp_valid
mem_addr  out  ADDR_W  word index = req_addr[ADDR_W+1:2]
mem_wdata  out  32  write data to memory
mem_we  out  1  memory write strobe
mem_re  out  1  memory read strobe; mem_rdata is registered by memory at the same edge
mem_rdata  in  32  memory read data, valid the cycle after the mem_re edge
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, resp_valid=0, resp_rdata=0, resp_err=0. All outputs except req_ready and busy are registered.
- Accept: req_valid && req_ready at a rising edge while rst=0. The block latches we, size, signed, addr[1:0], word index and wdata. req_ready is 0 in every state except IDLE.
- States: IDLE, RD, CAP, WR, RESP.
- Error check at accept:
  - half with addr[0]=1;
  - word with addr[1:0]!=0;
  - size 11;
  - out-of-range address.
  Any of these goes IDLE->RESP with resp_err=1 and resp_rdata=0. mem_re and mem_we are never asserted for an erroring request.
- Load: IDLE->RD (mem_re=1 for exactly one cycle) ->CAP (mem_rdata valid) ->RESP (resp_valid=1, extracted data) ->IDLE. resp_valid is high in the 3rd cycle after the accept edge.
- Word store: IDLE->WR (mem_we=1 for one cycle, mem_wdata=req_wdata) ->RESP ->IDLE. resp_valid is high in the 2nd cycle after accept.
- Sub-word store: IDLE->RD->CAP. At the CAP edge the block merges the new lane into mem_rdata. It then goes ->WR (merged word) ->RESP ->IDLE. resp_valid is high in the 4th cycle after accept.
- Lane selection is little-endian:
  - byte offset o=addr[1:0] selects bits [8o+7:8o];
  - addr[1] selects the half [15:0] or [31:16].
- Extension: signed replicates the lane MSB; unsigned fills with zero. Word loads ignore req_signed.
- mem_re and mem_we are never high in the same cycle. mem_addr holds its last value when both are low.
- No response backpressure: resp_valid lasts exactly one cycle. The next accept is possible in the cycle after RESP.
- req_* inputs are ignored when req_ready=0. Changes to req_* after accept do not affect the operation in flight.
- Reset mid-operation: all outputs go to reset values immediately (async). No response is produced for the aborted request. A store aborted before WR leaves memory unchanged.

Test Plan:
1. Memory preloaded with MEM[i]=i. After reset, lw at 0x14 -> one-cycle mem_re with mem_addr=5; 3 cycles after accept, resp_valid=1, resp_rdata=0x00000005, resp_err=0.
2. sw 0xDEADBEEF at 0x20, then lw 0x20 -> one-cycle mem_we with mem_addr=8, mem_wdata=0xDEADBEEF; load returns 0xDEADBEEF; req_ready=0 throughout each operation.
3. sb 0x000000A5 at 0x21 -> RD, CAP, WR sequence; MEM[8]=0xDEADA5EF. lb signed at 0x21 -> 0xFFFFFFA5; lbu at 0x21 -> 0x000000A5; lbu at 0x23 -> 0x000000DE.
4. sh 0x8001 at 0x22 -> MEM[8]=0x8001A5EF. lh at 0x22 -> 0xFFFF8001; lhu at 0x22 -> 0x00008001.
5. lw at 0x22, lh at 0x23, size=11 at 0x0, and lw at 0x400 -> each gives resp_err=1, resp_rdata=0, resp_valid 1 cycle after accept, and no mem_re or mem_we pulse.
6. sb 0x11 at 0x24 with rst asserted mid-cycle during CAP -> mem_re/mem_we drop immediately, no resp_valid, req_ready=1 after release, MEM[9] still 9. A subsequent lw at 0x24 returns 0x00000009.
